// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg: shared size encodings, FSM states and alignment rule for   |
// | the data memory load/store unit.            Revision: 1.0            |
// +----------------------------------------------------------------------+
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // The reserved size is treated as an error just like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_align: little-endian lane steering for stores and load          |
// | extraction with sign/zero extension.        Revision: 1.0            |
// +----------------------------------------------------------------------+
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        unsigned_ld,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    assign half_sel = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
    assign byte_sel = addr_lo[0] ? half_sel[15:8]    : half_sel[7:0];

    // Store data is replicated across lanes; the byte enables pick the live lane.
    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = wdata;
        load_data  = rdata_word;
        case (size)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                load_data  = {{24{byte_sel[7] & ~unsigned_ld}}, byte_sel};
            end
            SZ_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                load_data  = {{16{half_sel[15] & ~unsigned_ld}}, half_sel};
            end
            SZ_WORD: begin
                byte_en = 4'b1111;
            end
            default: begin
                byte_en = 4'b0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_memory_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_memory_lsu: byte-addressed 32-bit data memory with MIPS sizes,  |
// | valid/ready handshake and programmable wait states. Revision: 1.0    |
// +----------------------------------------------------------------------+
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

    state_e            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [IDX_W+1:0]  addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              w_accept;
    logic              w_commit;
    logic              w_from_idle;
    logic              w_sel_we;
    logic [1:0]        w_sel_size;
    logic              w_sel_unsigned;
    logic [IDX_W+1:0]  w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [IDX_W-1:0]  w_idx;
    logic              w_misalign;
    logic [3:0]        w_byte_en;
    logic [31:0]       w_wdata_lane;
    logic [31:0]       w_load_data;
    logic [31:0]       w_rword;

    logic [31:0]       mem [DEPTH_WORDS];

    generate
        if (ADDR_W > IDX_W + 2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];
        end
    endgenerate

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign w_accept  = req_valid && req_ready;

    // With no wait states the commit edge is the accept edge, so the live
    // request fields are used directly instead of the registered copy.
    assign w_from_idle    = (state_q == IDLE);
    assign w_sel_we       = w_from_idle ? req_we               : we_q;
    assign w_sel_size     = w_from_idle ? req_size             : size_q;
    assign w_sel_unsigned = w_from_idle ? req_unsigned         : unsigned_q;
    assign w_sel_addr     = w_from_idle ? req_addr[IDX_W+1:0]  : addr_q;
    assign w_sel_wdata    = w_from_idle ? req_wdata            : wdata_q;

    assign w_idx      = w_sel_addr[IDX_W+1:2];
    assign w_rword    = mem[w_idx];
    assign w_misalign = is_misaligned(w_sel_size, w_sel_addr[1:0]);

    dmem_align u_align (
        .size        (w_sel_size),
        .addr_lo     (w_sel_addr[1:0]),
        .unsigned_ld (w_sel_unsigned),
        .wdata       (w_sel_wdata),
        .rdata_word  (w_rword),
        .byte_en     (w_byte_en),
        .wdata_lane  (w_wdata_lane),
        .load_data   (w_load_data)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        w_commit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    we_d       = req_we;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr[IDX_W+1:0];
                    wdata_d    = req_wdata;
                    wait_cnt_d = 4'd0;
                    if (WAIT_STATES == 0) begin
                        state_d  = RESP;
                        w_commit = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    state_d  = RESP;
                    w_commit = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d    = IDLE;
                wait_cnt_d = 4'd0;
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase

        if (w_commit) begin
            err_d   = w_misalign;
            rdata_d = (w_misalign || w_sel_we) ? 32'h0 : w_load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Array is not reset; rst_n gating keeps a store from landing while held in reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && w_sel_we && !w_misalign) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byte_en[b]) begin
                    mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_memory_lsu: two instances (0 and 3 wait states) driven by    |
// | directed and random requests against a byte-array model. Rev: 1.0    |
// +----------------------------------------------------------------------+
module tb_data_memory_lsu;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] R = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];

    logic [7:0]  mdl [2][1024];
    int          errors = 0;
    int          checks = 0;

    data_memory_lsu #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    data_memory_lsu #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array, values assembled arithmetically.
    task automatic model_op(input int d, input bit we, input bit [1:0] sz, input bit uns,
                            input bit [31:0] a, input bit [31:0] wd,
                            output bit [31:0] exp_rd, output bit exp_err);
        int     base;
        int     nb;
        longint v;
        base    = int'(a % 1024);
        exp_err = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
        exp_rd  = 32'h0;
        if (!exp_err) begin
            nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            if (we) begin
                for (int i = 0; i < nb; i++) mdl[d][base + i] = 8'((wd >> (8 * i)) % 256);
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v + (longint'(mdl[d][base + i]) << (8 * i));
                if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
                exp_rd = v[31:0];
            end
        end
    endtask

    task automatic do_op(input int d, input bit we, input bit [1:0] sz, input bit uns,
                         input bit [31:0] a, input bit [31:0] wd, input bit inject,
                         output logic [31:0] rd, output logic err);
        bit [31:0] exp_rd;
        bit        exp_err;
        int        lat;
        int        lowc;
        int        ws;
        ws = (d == 0) ? 0 : 3;
        model_op(d, we, sz, uns, a, wd, exp_rd, exp_err);
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
        req_unsigned[d] = uns; req_addr[d] = a; req_wdata[d] = wd;
        lat = 0;
        while (req_ready[d] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("accept_ready[%0d]", d), 32'(req_ready[d]), 32'd1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat  = 1;
        lowc = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            if (req_ready[d] === 1'b0) lowc++;
            if (inject && lat == 1) begin
                req_valid[d] = 1'b1; req_we[d] = 1'b1; req_size[d] = W;
                req_addr[d] = 32'h30; req_wdata[d] = 32'hBAD0BAD0;
            end
            if (inject && lat == 2) req_valid[d] = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (req_ready[d] === 1'b0) lowc++;
        check($sformatf("latency[%0d] a=%h", d, a), 32'(lat), 32'(1 + ws));
        check($sformatf("ready_low[%0d]", d), 32'(lowc), 32'(1 + ws));
        check($sformatf("rdata[%0d] we=%0d sz=%0d a=%h", d, we, sz, a), rsp_rdata[d], exp_rd);
        check($sformatf("err[%0d] sz=%0d a=%h", d, sz, a), 32'(rsp_err[d]), 32'(exp_err));
        rd  = rsp_rdata[d];
        err = rsp_err[d];
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          extra;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = W;
            req_unsigned[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready[%0d]", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("rst_rvalid[%0d]", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("rst_rdata[%0d]", d), rsp_rdata[d], 32'h0);
            check($sformatf("rst_err[%0d]", d), 32'(rsp_err[d]), 32'd0);
        end

        // Initialise the region used by every later access.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++)
                do_op(d, 1'b1, W, 1'b0, 32'(4 * w), $urandom, 1'b0, rd, er);

        do_op(0, 1'b1, W, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd, er);
        do_op(0, 1'b0, W, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
        check("lw_deadbeef", rd, 32'hDEADBEEF);
        do_op(0, 1'b1, B, 1'b0, 32'h11, 32'h80, 1'b0, rd, er);
        do_op(0, 1'b0, W, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
        check("lw_after_sb", rd, 32'hDEAD80EF);
        do_op(0, 1'b0, B, 1'b0, 32'h11, 32'h0, 1'b0, rd, er);
        check("lb_sign", rd, 32'hFFFFFF80);
        do_op(0, 1'b0, B, 1'b1, 32'h11, 32'h0, 1'b0, rd, er);
        check("lbu_zero", rd, 32'h00000080);
        do_op(0, 1'b0, H, 1'b0, 32'h12, 32'h0, 1'b0, rd, er);
        check("lh_sign", rd, 32'hFFFFDEAD);
        do_op(0, 1'b1, W, 1'b0, 32'h13, 32'h55555555, 1'b0, rd, er);
        check("sw_mis_err", 32'(er), 32'd1);
        check("sw_mis_rdata", rd, 32'h0);
        do_op(0, 1'b0, W, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
        check("lw_unchanged", rd, 32'hDEAD80EF);
        do_op(0, 1'b0, H, 1'b0, 32'h11, 32'h0, 1'b0, rd, er);
        check("lh_mis_err", 32'(er), 32'd1);
        do_op(0, 1'b0, R, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
        check("rsvd_err", 32'(er), 32'd1);
        do_op(0, 1'b1, W, 1'b0, 32'h400, 32'h12345678, 1'b0, rd, er);
        do_op(0, 1'b0, W, 1'b0, 32'h000, 32'h0, 1'b0, rd, er);
        check("wrap_lw", rd, 32'h12345678);

        // Busy-time request pulse must be dropped, not queued.
        do_op(1, 1'b1, W, 1'b0, 32'h30, 32'h11111111, 1'b0, rd, er);
        do_op(1, 1'b0, W, 1'b0, 32'h10, 32'h0, 1'b1, rd, er);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[1] === 1'b1) extra++;
        end
        check("ignored_no_rsp", 32'(extra), 32'd0);
        do_op(1, 1'b0, W, 1'b0, 32'h30, 32'h0, 1'b0, rd, er);
        check("ignored_no_write", rd, 32'h11111111);

        do_op(1, 1'b1, W, 1'b0, 32'h20, 32'h5, 1'b0, rd, er);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = W;
        req_addr[1] = 32'h20; req_wdata[1] = 32'hAAAAAAAA;
        check("rst_mid_pre_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(req_ready[1]), 32'd1);
        check("rst_mid_rvalid", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1, 1'b0, W, 1'b0, 32'h20, 32'h0, 1'b0, rd, er);
        check("rst_mid_lw", rd, 32'h5);

        for (int n = 0; n < 60; n++) begin
            bit [31:0] a;
            int        d;
            d = (n % 3 == 0) ? 1 : 0;
            a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            do_op(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), a, $urandom, 1'b0, rd, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
